// File: rtl/iol_gearbox.sv
// Multi-lane I/O gearbox: LSB-first RX deserialiser with bitslip, gap-free TX serialiser.
// Define IOL_GEARBOX_AUTOALIGN_EN to build the lane-0 training-word alignment FSM.
module iol_gearbox #(
  parameter int              CHANNELS      = 4,
  parameter int              GEAR          = 4,
  parameter logic [GEAR-1:0] TRAIN_PATTERN = 4'b1100
) (
  input  logic                     SCLK,
  input  logic                     RSTN,
  input  logic [CHANNELS-1:0]      rx_d,
  input  logic                     bitslip,
  output logic [CHANNELS*GEAR-1:0] rx_q,
  output logic                     rx_valid,
  input  logic [CHANNELS*GEAR-1:0] tx_d,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [CHANNELS-1:0]      tx_q,
  output logic                     aligned
);

  localparam int              CNT_W = (GEAR > 2) ? $clog2(GEAR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GEAR - 1);

  logic                     slip;
  logic [CNT_W-1:0]         rx_cnt_p0;
  logic [CHANNELS*GEAR-1:0] rx_sr_p0;
  logic                     rx_vld_p0;

  // RX stage 0: shift every lane, count bits; a slip cycle holds the counter
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_sr_p0  <= '0;
      rx_cnt_p0 <= '0;
      rx_vld_p0 <= 1'b0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        rx_sr_p0[n*GEAR +: GEAR] <= {rx_d[n], rx_sr_p0[n*GEAR+1 +: GEAR-1]};
      end
      rx_vld_p0 <= (rx_cnt_p0 == LAST) && !slip;
      if (!slip) begin
        rx_cnt_p0 <= (rx_cnt_p0 == LAST) ? '0 : rx_cnt_p0 + 1'b1;
      end
    end
  end

  // RX stage 1: publish the completed word together with its strobe
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_q     <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_vld_p0;
      if (rx_vld_p0) begin
        rx_q <= rx_sr_p0;
      end
    end
  end

`ifdef IOL_GEARBOX_AUTOALIGN_EN
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0] state;
  logic [1:0] match_cnt;
  logic       skip;
  logic       word_ok;
  logic       int_slip;

  assign word_ok  = (rx_q[GEAR-1:0] == TRAIN_PATTERN);
  assign int_slip = (state == SEARCH) && rx_valid && !skip && !word_ok;
  // External requests only move the boundary once locked; training owns it before that
  assign slip     = int_slip || ((state == LOCKED) && bitslip);

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= SEARCH;
      match_cnt <= '0;
      skip      <= 1'b0;
      aligned   <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (rx_valid) begin
            if (skip) begin
              skip <= 1'b0;
            end else if (!word_ok) begin
              skip <= 1'b1;
            end else begin
              state     <= CHECK;
              match_cnt <= '0;
            end
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (!word_ok) begin
              state <= SEARCH;
            end else if (match_cnt == 2'd3) begin
              state   <= LOCKED;
              aligned <= 1'b1;
            end else begin
              match_cnt <= match_cnt + 2'd1;
            end
          end
        end
        LOCKED: begin
          if (bitslip) begin
            state   <= SEARCH;
            aligned <= 1'b0;
          end
        end
        default: begin
          state   <= SEARCH;
          aligned <= 1'b0;
        end
      endcase
    end
  end
`else
  assign slip    = bitslip;
  assign aligned = 1'b0;
`endif

  logic                     tx_en;
  logic                     tx_busy;
  logic                     tx_fire;
  logic [CNT_W-1:0]         tx_cnt_p0;
  logic [CHANNELS*GEAR-1:0] tx_sr_p0;

  // Ready overlaps the last bit so consecutive words leave without a gap
  assign tx_ready = tx_en && (!tx_busy || (tx_cnt_p0 == LAST));
  assign tx_fire  = tx_valid && tx_ready;

  // TX stage 0: load on handshake, then walk remaining bits out LSB first
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      tx_en     <= 1'b0;
      tx_busy   <= 1'b0;
      tx_cnt_p0 <= '0;
      tx_sr_p0  <= '0;
      tx_q      <= '0;
    end else begin
      tx_en <= 1'b1;
      if (tx_fire) begin
        tx_busy   <= 1'b1;
        tx_cnt_p0 <= '0;
        for (int n = 0; n < CHANNELS; n++) begin
          tx_q[n]                  <= tx_d[n*GEAR];
          tx_sr_p0[n*GEAR +: GEAR] <= {1'b0, tx_d[n*GEAR+1 +: GEAR-1]};
        end
      end else if (tx_busy) begin
        if (tx_cnt_p0 == LAST) begin
          tx_busy <= 1'b0;
          tx_q    <= '0;
        end else begin
          tx_cnt_p0 <= tx_cnt_p0 + 1'b1;
          for (int n = 0; n < CHANNELS; n++) begin
            tx_q[n]                  <= tx_sr_p0[n*GEAR];
            tx_sr_p0[n*GEAR +: GEAR] <= {1'b0, tx_sr_p0[n*GEAR+1 +: GEAR-1]};
          end
        end
      end
    end
  end

endmodule
